// File: rtl/ram_burst_master_pkg.sv
// Shared types and default widths for the burst-mode RAM initiator.
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDRESS_SIZE = 20;
  localparam int unsigned DEF_DATA_WIDTH   = 32;
  localparam int unsigned DEF_LEN_WIDTH    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/ram_burst_master_if.sv
// Command, write-stream, read-stream and status signals of the burst master.
interface ram_burst_master_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH    = DEF_LEN_WIDTH
) ();

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_write;
  logic [ADDRESS_SIZE-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]    cmd_len;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [DATA_WIDTH-1:0]   wr_data;

  logic                    rd_valid;
  logic                    rd_ready;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    rd_last;

  logic                    done;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
    output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, done, busy
  );

endinterface

// File: rtl/ram_burst_master_counter.sv
// Burst address/beat counter: load start address and length, step on advance.
module ram_burst_counter
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int unsigned LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    adv_i,
  input  logic [ADDRESS_SIZE-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]    len_i,
  output logic [ADDRESS_SIZE-1:0] addr_o,
  output logic                    last_o
);

  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = addr_i;
      cnt_d  = len_i;
    end else if (adv_i) begin
      // address wraps modulo 2**ADDRESS_SIZE by natural overflow
      addr_d = addr_q + ADDRESS_SIZE'(1);
      cnt_d  = cnt_q - LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port async-read/sync-write RAM.
module ram_burst_master
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  ram_burst_master_if.slave       bus,
  output logic [ADDRESS_SIZE-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic                    ram_rdwr,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  state_e                  state_q, state_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    rd_last_q, rd_last_d;
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
  logic                    done_q, done_d;

  logic                    cmd_rdy;
  logic                    load;
  logic                    wr_beat;
  logic                    rd_cap;
  logic                    last_beat;

  // Holding off during the done cycle keeps back-to-back commands a cycle apart.
  assign cmd_rdy = (state_q == ST_IDLE) && !done_q && !rst;

  always_comb begin
    state_d    = state_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    done_d     = 1'b0;
    load       = 1'b0;
    wr_beat    = 1'b0;
    rd_cap     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid && cmd_rdy) begin
          load    = 1'b1;
          state_d = bus.cmd_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (bus.wr_valid) begin
          wr_beat = 1'b1;
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_READ: begin
        if (!rd_valid_q || bus.rd_ready) begin
          rd_cap     = 1'b1;
          rd_data_d  = ram_dout;
          rd_valid_d = 1'b1;
          rd_last_d  = last_beat;
          if (last_beat) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rd_valid_q && bus.rd_ready && rd_last_q) begin
          rd_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      done_q     <= done_d;
    end
  end

  ram_burst_counter #(
    .ADDRESS_SIZE (ADDRESS_SIZE),
    .LEN_WIDTH    (LEN_WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .adv_i  (wr_beat || rd_cap),
    .addr_i (bus.cmd_addr),
    .len_i  (bus.cmd_len),
    .addr_o (ram_addr),
    .last_o (last_beat)
  );

  assign ram_rdwr      = !wr_beat;
  assign ram_din       = bus.wr_data;

  assign bus.cmd_ready = cmd_rdy;
  assign bus.wr_ready  = (state_q == ST_WRITE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.done      = done_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ram_burst_master.sv
// Self-checking bench: behavioural RAM plus an expected-memory model built from burst rules.
module tb_ram_burst_master;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned LW    = 8;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;
  logic          ram_rdwr;

  ram_burst_master_if #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  ram_burst_master #(.ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_rdwr (ram_rdwr),
    .ram_dout (ram_dout)
  );

  // RAM device: async read, write on posedge when RDwr=0; every write is logged.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   wlog_addr[$];
  logic [DW-1:0] wlog_data[$];

  always @(posedge clk) begin
    if (ram_rdwr === 1'b0) begin
      mem[ram_addr] <= ram_din;
      wlog_addr.push_back(int'(ram_addr));
      wlog_data.push_back(ram_din);
    end
  end
  assign ram_dout = mem[ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_cmd(input bit wr, input int unsigned a, input int unsigned len);
    int t;
    t = 0;
    while (bus.cmd_ready !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    chk("cmd_ready_wait", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = LW'(len);
    tick();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_len   = LW'($urandom);
  endtask

  // mode 0: wr_valid always 1; 1: alternating 1,0,1,...; 2: random gaps
  task automatic write_burst(input int unsigned a, input int unsigned len, input int mode);
    logic [DW-1:0] d[$];
    int unsigned   base, i, cyc;
    bit            v;
    for (int unsigned k = 0; k <= len; k++) d.push_back($urandom);
    base = wlog_addr.size();
    issue_cmd(1'b1, a, len);
    chk("wr_busy", bus.busy, 1);
    i   = 0;
    cyc = 0;
    while (i <= len && cyc < 4 * (len + 1) + 8) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      bus.wr_valid = v;
      bus.wr_data  = v ? d[i] : $urandom;
      #1;
      chk("wr_ram_rdwr", ram_rdwr, !v);
      chk("wr_ram_addr", ram_addr, (a + i) % DEPTH);
      chk("wr_ready", bus.wr_ready, 1);
      chk("wr_done_early", bus.done, 0);
      if (v) i++;
      tick();
      cyc++;
    end
    bus.wr_valid = 1'b0;
    chk("wr_done", bus.done, 1);
    chk("wr_idle", bus.busy, 0);
    chk("wr_count", wlog_addr.size() - base, len + 1);
    for (int unsigned k = 0; k <= len; k++) begin
      if (base + k < wlog_addr.size()) begin
        chk("wr_log_addr", wlog_addr[base + k], (a + k) % DEPTH);
        chk("wr_log_data", wlog_data[base + k], d[k]);
      end
      ref_mem[(a + k) % DEPTH] = d[k];
    end
    tick();
    chk("wr_done_pulse", bus.done, 0);
  endtask

  // mode 0: rd_ready always 1; 1: repeating 1,0,0,1; 2: random
  task automatic read_burst(input int unsigned a, input int unsigned len, input int mode);
    int unsigned k, cyc;
    bit          r;
    issue_cmd(1'b0, a, len);
    k   = 0;
    cyc = 0;
    while (k <= len && cyc < 6 * (len + 1) + 8) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 4 == 0 || cyc % 4 == 3)
                                           : 1'($urandom_range(0, 1));
      bus.rd_ready = r;
      #1;
      chk("rd_ram_rdwr", ram_rdwr, 1);
      if (mode == 0) chk("rd_valid_rate", bus.rd_valid, cyc >= 1);
      if (bus.rd_valid === 1'b1) begin
        chk("rd_data", bus.rd_data, ref_mem[(a + k) % DEPTH]);
        chk("rd_last", bus.rd_last, k == len);
        if (r) k++;
      end
      tick();
      cyc++;
    end
    bus.rd_ready = 1'b0;
    chk("rd_done", bus.done, 1);
    chk("rd_valid_clear", bus.rd_valid, 0);
    chk("rd_idle", bus.busy, 0);
    tick();
    chk("rd_done_pulse", bus.done, 0);
  endtask

  initial begin
    int unsigned base, ra, rl;
    logic [DW-1:0] d0, d1;
    for (int unsigned k = 0; k < DEPTH; k++) ref_mem[k] = '0;
    rst          = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    tick(); tick(); tick();

    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_ram_rdwr", ram_rdwr, 1);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_rd_last", bus.rd_last, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ram_addr", ram_addr, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_cmd_ready", bus.cmd_ready, 1);

    write_burst(32'h10, 3, 0);
    read_burst(32'h10, 3, 0);
    read_burst(32'h10, 3, 1);
    write_burst(DEPTH - 1, 1, 0);
    read_burst(DEPTH - 1, 1, 0);
    write_burst(32'h20, 2, 1);
    read_burst(32'h20, 2, 1);
    write_burst(32'h05, 0, 0);
    read_burst(32'h05, 0, 0);

    // reset during the third beat of an 8-beat write
    d0   = $urandom;
    d1   = $urandom;
    base = wlog_addr.size();
    issue_cmd(1'b1, 32'h30, 7);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d0;
    tick();
    bus.wr_data  = d1;
    tick();
    bus.wr_data  = $urandom;
    #1;
    chk("abort_beat3_rdwr", ram_rdwr, 0);
    rst = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd_valid", bus.rd_valid, 0);
    chk("abort_ram_rdwr", ram_rdwr, 1);
    chk("abort_wr_ready", bus.wr_ready, 0);
    chk("abort_cmd_ready", bus.cmd_ready, 0);
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick();
    bus.wr_valid = 1'b0;
    chk("abort_write_count", wlog_addr.size() - base, 2);
    ref_mem[32'h30] = d0;
    ref_mem[32'h31] = d1;
    read_burst(32'h30, 1, 0);

    // reset while a read beat is held by backpressure
    issue_cmd(1'b0, 32'h10, 3);
    tick(); tick();
    chk("hold_rd_valid", bus.rd_valid, 1);
    rst = 1'b1;
    #1;
    chk("rst_hold_rd_valid", bus.rd_valid, 0);
    chk("rst_hold_busy", bus.busy, 0);
    tick();
    rst = 1'b0;
    tick();

    for (int n = 0; n < 6; n++) begin
      ra = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, 12);
      write_burst(ra, rl, 2);
      read_burst(ra, rl, 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
